// File: rtl/gf_mul_sched.sv
// Two-requester GF(2^8) multiplier: round-robin accept, 8-step shift-and-add
// multiply, result held until the consumer handshakes.
module gf_mul_sched #(
    parameter logic [7:0]  POLY = 8'h1B,
    parameter int unsigned ITER = 8
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       req0_ready,

    input  logic       req1_valid,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       req1_ready,

    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_prod,
    output logic       res_id,

    output logic       busy
);

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     p_q, p_d;
    logic             id_q, id_d;
    logic             res_valid_q, res_valid_d;
    logic [W-1:0]     res_prod_q, res_prod_d;
    logic             res_id_q, res_id_d;

    logic             grant0_c, grant1_c;
    logic [W-1:0]     p_iter_c, a_iter_c, b_iter_c;

    // Round-robin: on a tie the requester not granted last time wins.
    always_comb begin
        grant0_c = rst_n && req0_valid && (!req1_valid || last_grant_q);
        grant1_c = rst_n && req1_valid && (!req0_valid || !last_grant_q);
    end

    // One shift-and-add step: accumulate, then multiply a by x modulo the polynomial.
    always_comb begin
        p_iter_c = b_q[0] ? (p_q ^ a_q) : p_q;
        a_iter_c = {a_q[W-2:0], 1'b0} ^ (a_q[W-1] ? POLY : W'(0));
        b_iter_c = b_q >> 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            p_q          <= '0;
            id_q         <= 1'b0;
            res_valid_q  <= 1'b0;
            res_prod_q   <= '0;
            res_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            p_q          <= p_d;
            id_q         <= id_d;
            res_valid_q  <= res_valid_d;
            res_prod_q   <= res_prod_d;
            res_id_q     <= res_id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        p_d          = p_q;
        id_d         = id_q;
        res_valid_d  = res_valid_q;
        res_prod_d   = res_prod_q;
        res_id_d     = res_id_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                req0_ready = grant0_c;
                req1_ready = grant1_c;
                if (grant0_c || grant1_c) begin
                    a_d          = grant1_c ? req1_a : req0_a;
                    b_d          = grant1_c ? req1_b : req0_b;
                    p_d          = '0;
                    id_d         = grant1_c;
                    last_grant_d = grant1_c;
                    cnt_d        = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                p_d   = p_iter_c;
                a_d   = a_iter_c;
                b_d   = b_iter_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    res_prod_d  = p_iter_c;
                    res_id_d    = id_q;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_valid = res_valid_q;
    assign res_prod  = res_prod_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gf_mul_sched.sv
// Self-checking bench for gf_mul_sched: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_gf_mul_sched;

    localparam logic [7:0] POLY = 8'h1B;

    logic       clk, rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       res_valid, res_ready, res_id, busy;
    logic [7:0] res_prod;

    int errors = 0;
    int checks = 0;

    gf_mul_sched #(.POLY(POLY), .ITER(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_prod   (res_prod),
        .res_id     (res_id),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference product: carry-less multiply, then polynomial long division.
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        logic [15:0] m;
        prod = 16'h0;
        m    = {7'b0, 1'b1, POLY};
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (prod[i]) prod = prod ^ (m << (i - 8));
        return prod[7:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b;
        end
    endtask

    // One complete operation from an idle block; checks grant, exact latency, result, release.
    task automatic run_op(input string nm, input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp, input logic rr_early);
        int early;
        res_ready = rr_early;
        set_req(id, 1'b1, a, b);
        #1;
        check({nm, " ready"}, 32'({req1_ready, req0_ready}), (id == 0) ? 32'd1 : 32'd2);
        tick();
        set_req(id, 1'b0, 8'($urandom), 8'($urandom));
        #1;
        check({nm, " busy/ready in run"}, 32'({busy, req1_ready, req0_ready}), 32'h4);
        early = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            set_req(id, 1'b0, 8'($urandom), 8'($urandom));
            if (res_valid) early++;
        end
        check({nm, " early res_valid count"}, 32'(early), 32'd0);
        tick();
        check({nm, " result {valid,id,prod}"}, 32'({res_valid, res_id, res_prod}),
              32'({1'b1, id[0], exp}));
        res_ready = 1'b1;
        tick();
        check({nm, " release {valid,busy}"}, 32'({res_valid, busy}), 32'h0);
        res_ready = 1'b0;
    endtask

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t       tbl[8];
    logic [7:0] got_p[3];
    logic       got_id[3];
    logic [7:0] exp_cp[3];
    logic       exp_cid[3];
    int         n, cnt;

    logic       v0, v1, e0, e1, ev, lg_m, outstanding, exp_id;
    logic [7:0] a0, b0, a1, b1, exp_p;
    int         cyc, acc_edge;

    initial begin
        tbl[0] = '{0, 8'h00, 8'hFF, 8'h00};
        tbl[1] = '{1, 8'hFF, 8'h01, 8'hFF};
        tbl[2] = '{0, 8'h80, 8'h02, 8'h1B};
        tbl[3] = '{1, 8'h57, 8'h13, 8'hFE};
        tbl[4] = '{0, 8'h07, 8'h03, 8'h09};
        tbl[5] = '{1, 8'h02, 8'h80, 8'h1B};
        tbl[6] = '{0, 8'h53, 8'hCA, 8'h01};
        tbl[7] = '{1, 8'h00, 8'h00, 8'h00};

        // Reset held two edges with a pending request.
        rst_n = 1'b0; res_ready = 1'b0;
        set_req(0, 1'b1, 8'h57, 8'h83);
        set_req(1, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("reset {req0_ready,res_valid,busy}", 32'({req0_ready, res_valid, busy}), 32'h0);
        end
        rst_n = 1'b1;
        run_op("single 57*83", 0, 8'h57, 8'h83, 8'hC1, 1'b0);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p, 1'(i % 2));

        // Contention from a fresh reset: req0 wins the first tie, then alternation.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        set_req(0, 1'b1, 8'h07, 8'h03);
        set_req(1, 1'b1, 8'h02, 8'h80);
        res_ready = 1'b1;
        exp_cp[0] = 8'h09; exp_cid[0] = 1'b0;
        exp_cp[1] = 8'h1B; exp_cid[1] = 1'b1;
        exp_cp[2] = 8'h09; exp_cid[2] = 1'b0;
        n = 0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            tick();
            if (res_valid) begin
                got_p[n] = res_prod; got_id[n] = res_id; n++;
            end
        end
        set_req(0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 8'h00, 8'h00);
        check("contention result count", 32'(n), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < n)
                check($sformatf("contention result%0d {id,prod}", i), 32'({got_id[i], got_p[i]}),
                      32'({exp_cid[i], exp_cp[i]}));
        tick();
        res_ready = 1'b0;

        // Backpressure in DONE with req1 held waiting.
        set_req(0, 1'b1, 8'h57, 8'h83);
        #1;
        tick();
        set_req(0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b1, 8'h10, 8'h10);
        for (int k = 0; k < 8; k++) tick();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("backpressure hold%0d", k),
                  32'({res_valid, res_id, res_prod, busy, req0_ready, req1_ready}),
                  32'({1'b1, 1'b0, 8'hC1, 1'b1, 1'b0, 1'b0}));
            if (k < 5) tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("backpressure release {valid,busy}", 32'({res_valid, busy}), 32'h0);
        check("held req1 granted in idle", 32'({req1_ready, req0_ready}), 32'h2);
        set_req(1, 1'b0, 8'h00, 8'h00);
        tick();

        // Reset after four iterations discards the operation.
        set_req(0, 1'b1, 8'h12, 8'h34);
        #1;
        tick();
        set_req(0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid-run reset {valid,busy}", 32'({res_valid, busy}), 32'h0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (res_valid) cnt++;
        end
        check("discarded op res_valid count", 32'(cnt), 32'd0);
        run_op("post-reset 57*13", 1, 8'h57, 8'h13, 8'hFE, 1'b0);

        // Randomized traffic against the transaction-level model.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        lg_m = 1'b1; outstanding = 1'b0; cyc = 0; acc_edge = 0;
        exp_p = 8'h00; exp_id = 1'b0;
        for (int c = 0; c < 300; c++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            a0 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            b0 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            a1 = 8'($urandom);
            b1 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            set_req(0, v0, a0, b0);
            set_req(1, v1, a1, b1);
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            e0 = !outstanding && v0 && (!v1 || lg_m);
            e1 = !outstanding && v1 && (!v0 || !lg_m);
            ev = outstanding && (cyc >= acc_edge + 8);
            check($sformatf("rand c%0d readies", c), 32'({req1_ready, req0_ready}), 32'({e1, e0}));
            check($sformatf("rand c%0d {res_valid,busy}", c), 32'({res_valid, busy}),
                  32'({ev, outstanding}));
            if (ev)
                check($sformatf("rand c%0d {id,prod}", c), 32'({res_id, res_prod}),
                      32'({exp_id, exp_p}));
            if (ev && res_ready) begin
                outstanding = 1'b0;
            end else if (e0 || e1) begin
                outstanding = 1'b1;
                acc_edge    = cyc + 1;
                exp_id      = e1;
                exp_p       = e1 ? gf_ref(a1, b1) : gf_ref(a0, b0);
                lg_m        = e1;
            end
            tick();
            cyc++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf_mul_sched.md
GF_MUL_SCHED -- requirements
Module: gf_mul_sched

Interface
REQ-001 Parameter POLY, default 8'h1B, is the low byte of the GF(2^8) reduction polynomial (x^8 term implied; default = AES 0x11B).
REQ-002 Parameter ITER, default 8, is the number of shift-and-add iterations per multiply; only 8 is supported.
REQ-003 clk  input  1  rising-edge system clock, the only clock.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 req0_valid  input  1  requester 0 has an operand pair.
REQ-006 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-007 req0_ready  output  1  requester 0 accepted this cycle when high with req0_valid.
REQ-008 req1_valid, req1_a, req1_b, req1_ready  same widths/meaning as the req0 set, for requester 1.
REQ-009 res_valid  output  1  res_prod/res_id hold a completed result.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_prod  output  8  GF(2^8) product a*b mod (x^8 + POLY).
REQ-012 res_id  output  1  index of the requester that issued the result.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE, exactly one reqN_ready SHALL be high, and only if that reqN_valid is high; the other ready SHALL be low.
REQ-016 Arbitration SHALL be round-robin:
- one valid: that requester wins;
- both valid: the requester not granted last wins;
- last_grant resets to 1, so req0 wins the first tie.
REQ-017 On the accepting edge the block SHALL:
- capture a and b into internal registers;
- clear the product accumulator;
- record the id and update last_grant;
- clear the iteration counter;
- enter RUN.
REQ-018 Operand inputs SHALL be ignored after acceptance.
REQ-019 Each RUN edge SHALL perform one iteration, in this order:
- if b bit0 = 1, p ^= a;
- carry = a bit7 (value weight 128);
- a = a<<1, truncated to 8 bits;
- if carry, a ^= POLY;
- b = b>>1;
- counter increments.
REQ-020 After the ITER-th RUN edge the state SHALL be DONE with res_valid = 1.
- Latency from the accepting edge to res_valid visible is exactly 8 clk edges.
- Latency is independent of operand values, including zero operands.
REQ-021 In DONE, res_prod and res_id SHALL stay stable until an edge where res_valid & res_ready; that edge SHALL clear res_valid and return to IDLE.
REQ-022 Both reqN_ready SHALL be low in RUN and DONE; the earliest next acceptance is the cycle after the result handshake (minimum 10 cycles per operation).
REQ-023 A valid dropped before acceptance SHALL have no effect; a request held through RUN/DONE SHALL be considered in the next IDLE cycle.
REQ-024 res_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 While rst_n is low at a rising edge, the block SHALL take these reset values:
- state = IDLE, last_grant = 1;
- counter, operand, accumulator registers = 0;
- res_valid = 0, res_prod = 8'h00, res_id = 0.
REQ-026 reqN_ready SHALL be forced low in any cycle where rst_n is low.
REQ-027 busy SHALL be 0 after reset.
REQ-028 Reset in RUN or DONE SHALL discard the operation; no res_valid SHALL appear for it.

Verification
REQ-029 Reset: rst_n low 2 cycles with req0_valid = 1 -> req0_ready = 0, res_valid = 0, busy = 0 throughout; req0 accepted in the first cycle after rst_n rises.
REQ-030 Single request: req0 a = 8'h57, b = 8'h83 -> req0_ready high in the same cycle; res_valid rises exactly 8 edges later with res_prod = 8'hC1, res_id = 0.
REQ-031 Contention: both valid continuously, req0 = (8'h07, 8'h03), req1 = (8'h02, 8'h80), res_ready = 1 -> results appear in order:
- 8'h09 id 0;
- 8'h1B id 1;
- 8'h09 id 0.
REQ-032 Backpressure: res_ready low for 5 cycles in DONE -> res_valid, res_prod and res_id stay stable, busy = 1, no reqN_ready; completion on the first res_ready high edge.
REQ-033 Reset mid-RUN after 4 iterations -> res_valid never asserts; a following req1 (8'h57, 8'h13) yields 8'hFE, id 1.
REQ-034 Boundaries:
- 8'h00 * 8'hFF -> 8'h00;
- 8'hFF * 8'h01 -> 8'hFF;
- 8'h80 * 8'h02 -> 8'h1B;
- each with exactly 8-edge latency.
